// File: rtl/pcm_fifo_reader.sv
// Audio FIFO consumer: a phase accumulator paces frame fetches, and each frame's
// 1/2/4 popped bytes are assembled into signed 16-bit left/right samples.
module pcm_fifo_reader #(
    parameter int unsigned RATE_MAX = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic [7:0]  rate,
    input  logic        mode_16bit,
    input  logic        mode_stereo,
    input  logic [7:0]  fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] left_data,
    output logic [15:0] right_data,
    output logic        sample_strobe,
    output logic        underrun,
    output logic        busy
);

    localparam logic [7:0] RateCap = 8'(RATE_MAX);

    typedef enum logic [1:0] {StIdle, StFetch, StCapture, StDone} state_e;

    state_e          state_q, state_d;
    logic [6:0]      acc_q, acc_d;
    logic            pending_q, pending_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] bytes_q, bytes_d;
    logic            is16_q, is16_d;
    logic            stereo_q, stereo_d;
    logic [15:0]     left_q, left_d;
    logic [15:0]     right_q, right_d;

    logic [7:0]      rate_eff;
    logic [7:0]      sum;
    logic            overflow;
    logic            start;
    logic [1:0]      last_idx;
    logic [3:0][7:0] bytes_c;

    always_comb begin
        rate_eff = (rate > RateCap) ? RateCap : rate;
        sum      = {1'b0, acc_q} + rate_eff;
        overflow = sample_tick & sum[7];
        acc_d    = sample_tick ? sum[6:0] : acc_q;
    end

    // Index of the final byte of the latched frame: 0, 1 or 3.
    assign last_idx = {is16_q & stereo_q, is16_q | stereo_q};

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        idx_d         = idx_q;
        bytes_d       = bytes_q;
        is16_d        = is16_q;
        stereo_d      = stereo_q;
        left_d        = left_q;
        right_d       = right_q;
        bytes_c       = bytes_q;
        start         = 1'b0;
        fifo_rd_en    = 1'b0;
        underrun      = 1'b0;
        sample_strobe = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (overflow || pending_q) begin
                    start     = 1'b1;
                    pending_d = 1'b0;
                end
            end
            StFetch: begin
                if (overflow) pending_d = 1'b1;
                if (fifo_empty) begin
                    underrun = 1'b1;
                    state_d  = StIdle;
                end else begin
                    fifo_rd_en = 1'b1;
                    state_d    = StCapture;
                end
            end
            StCapture: begin
                if (overflow) pending_d = 1'b1;
                bytes_c[idx_q] = fifo_rddata;
                bytes_d        = bytes_c;
                if (idx_q == last_idx) begin
                    if (is16_q) begin
                        left_d  = {bytes_c[1], bytes_c[0]};
                        right_d = stereo_q ? {bytes_c[3], bytes_c[2]} : {bytes_c[1], bytes_c[0]};
                    end else begin
                        left_d  = {bytes_c[0], 8'h00};
                        right_d = stereo_q ? {bytes_c[1], 8'h00} : {bytes_c[0], 8'h00};
                    end
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                sample_strobe = 1'b1;
                state_d       = StIdle;
                // A same-cycle overflow with pending set replaces the consumed pending.
                if (overflow || pending_q) begin
                    start     = 1'b1;
                    pending_d = pending_q & overflow;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d  = StFetch;
            idx_d    = 2'd0;
            bytes_d  = '0;
            is16_d   = mode_16bit;
            stereo_d = mode_stereo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            pending_q <= 1'b0;
            idx_q     <= '0;
            bytes_q   <= '0;
            is16_q    <= 1'b0;
            stereo_q  <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            bytes_q   <= bytes_d;
            is16_q    <= is16_d;
            stereo_q  <= stereo_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pcm_fifo_reader.sv
// Bench for pcm_fifo_reader: a frame-timeline model predicts every output each cycle,
// and directed scenarios pin latencies and sample values with literal expectations.
module tb_pcm_fifo_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic [7:0]  rate;
    logic        mode_16bit;
    logic        mode_stereo;
    logic [7:0]  fifo_rddata = 8'h00;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        sample_strobe;
    logic        underrun;
    logic        busy;

    pcm_fifo_reader #(.RATE_MAX(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .rate         (rate),
        .mode_16bit   (mode_16bit),
        .mode_stereo  (mode_stereo),
        .fifo_rddata  (fifo_rddata),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_strobe(sample_strobe),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Byte FIFO: the stimulus writes mem/wp, the pop side owns rp.
    logic [7:0] mem [0:255];
    int         wp = 0;
    int         rp = 0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en && (rp != wp)) begin
            fifo_rddata <= mem[rp[7:0]];
            rp          <= rp + 1;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0;

    // Model state: frame timeline, not a state machine.
    int          mrp = 0;
    int          m_acc = 0;
    bit          m_pend = 0;
    bit          m_active = 0;
    int          m_fstart;
    int          m_n;
    bit          m_p16, m_pst;
    logic [7:0]  m_b [4];
    logic [15:0] m_l = 16'h0;
    logic [15:0] m_r = 16'h0;

    // Observations of the DUT for the literal checks.
    int          rd_cnt, st_cnt, ur_cnt, first_st, last_st, last_ur;
    int          rd_cyc [8];
    logic [15:0] st_l0, st_r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[7:0]] = b;
        wp++;
    endtask

    task automatic clear_log();
        rd_cnt = 0; st_cnt = 0; ur_cnt = 0;
        first_st = -1; last_st = -1; last_ur = -1;
        for (int i = 0; i < 8; i++) rd_cyc[i] = -1;
    endtask

    task automatic start_frame();
        m_active = 1;
        m_fstart = cyc + 1;
        m_p16    = mode_16bit;
        m_pst    = mode_stereo;
        m_n      = m_p16 ? (m_pst ? 4 : 2) : (m_pst ? 2 : 1);
    endtask

    // One clock: predict and compare at the falling edge, return just after the rising edge.
    task automatic cycle();
        int   ph;
        int   eff;
        bit   ovf;
        logic e_rd, e_st, e_ur, e_busy;
        @(negedge clk);
        e_rd = 0; e_st = 0; e_ur = 0; e_busy = 0;
        if (rst) begin
            m_active = 0; m_pend = 0; m_acc = 0; m_l = 16'h0; m_r = 16'h0;
        end else begin
            eff = (int'(rate) > 128) ? 128 : int'(rate);
            ovf = sample_tick && (m_acc + eff >= 128);
            if (m_active) begin
                e_busy = 1;
                ph = cyc - m_fstart;
                if (ph == 2 * m_n) begin
                    e_st = 1;
                    m_active = 0;
                    if (m_p16) begin
                        m_l = {m_b[1], m_b[0]};
                        m_r = m_pst ? {m_b[3], m_b[2]} : m_l;
                    end else begin
                        m_l = {m_b[0], 8'h00};
                        m_r = m_pst ? {m_b[1], 8'h00} : m_l;
                    end
                    if (m_pend || ovf) begin
                        start_frame();
                        m_pend = m_pend && ovf;
                    end
                end else begin
                    if (ovf) m_pend = 1;
                    if (ph % 2 == 0) begin
                        if (mrp == wp) begin
                            e_ur = 1;
                            m_active = 0;
                        end else begin
                            e_rd = 1;
                            m_b[ph / 2] = mem[mrp[7:0]];
                            mrp++;
                        end
                    end
                end
            end else if (ovf || m_pend) begin
                start_frame();
                m_pend = 0;
            end
            if (sample_tick) m_acc = (m_acc + eff) % 128;
        end
        chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));
        chk("strobe", 32'(sample_strobe), 32'(e_st));
        chk("underrun", 32'(underrun), 32'(e_ur));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("left", 32'(left_data), 32'(m_l));
        chk("right", 32'(right_data), 32'(m_r));
        if (fifo_rd_en === 1'b1) begin
            if (rd_cnt < 8) rd_cyc[rd_cnt] = cyc;
            rd_cnt++;
        end
        if (sample_strobe === 1'b1) begin
            if (st_cnt == 0) begin
                first_st = cyc; st_l0 = left_data; st_r0 = right_data;
            end
            st_cnt++;
            last_st = cyc;
        end
        if (underrun === 1'b1) begin
            ur_cnt++;
            last_ur = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        t0 = cyc;
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sample_tick = 1'b0; rate = 8'd0; mode_16bit = 1'b0; mode_stereo = 1'b0;
        clear_log();
        repeat (3) cycle();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_left", 32'(left_data), 32'h0);
        chk("reset_rd_en", 32'(fifo_rd_en), 32'h0);
        rst = 1'b0;
        repeat (2) cycle();

        // 8-bit mono, single byte
        rate = 8'd128;
        push(8'h80);
        clear_log();
        tick();
        repeat (5) cycle();
        chk("m8_first_rd", 32'(rd_cyc[0]), 32'(t0 + 1));
        chk("m8_strobe_cyc", 32'(last_st), 32'(t0 + 3));
        chk("m8_counts", 32'(rd_cnt * 16 + st_cnt), 32'h11);
        chk("m8_left", 32'(left_data), 32'h8000);
        chk("m8_right", 32'(right_data), 32'h8000);

        // 16-bit stereo
        mode_16bit = 1'b1; mode_stereo = 1'b1;
        push(8'h34); push(8'h12); push(8'h78); push(8'h56);
        clear_log();
        tick();
        repeat (11) cycle();
        for (int i = 0; i < 4; i++) chk("s16_rd_cyc", 32'(rd_cyc[i]), 32'(t0 + 1 + 2 * i));
        chk("s16_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("s16_strobe_cyc", 32'(last_st), 32'(t0 + 9));
        chk("s16_left", 32'(left_data), 32'h1234);
        chk("s16_right", 32'(right_data), 32'h5678);

        // rate 64, 8-bit stereo: overflow on ticks 2 and 4
        rate = 8'd64; mode_16bit = 1'b0; mode_stereo = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        clear_log();
        repeat (4) begin
            tick();
            repeat (8) cycle();
        end
        chk("r64_frames", 32'(st_cnt), 32'd2);
        chk("r64_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("r64_strobe_cyc", 32'(last_st), 32'(t0 + 5));
        chk("r64_first_left", 32'(st_l0), 32'h1100);
        chk("r64_left", 32'(left_data), 32'h3300);
        chk("r64_right", 32'(right_data), 32'h4400);

        // rate 0: stopped
        rate = 8'd0;
        clear_log();
        repeat (10) begin
            tick();
            cycle();
        end
        chk("r0_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("r0_strobes", 32'(st_cnt), 32'd0);

        // rate above the cap behaves as 128: every tick overflows
        rate = 8'd200; mode_stereo = 1'b0;
        push(8'h7f); push(8'h81);
        clear_log();
        repeat (2) begin
            tick();
            repeat (4) cycle();
        end
        chk("clamp_frames", 32'(st_cnt), 32'd2);
        chk("clamp_left", 32'(left_data), 32'h8100);

        // 16-bit mono underrun after one byte
        rate = 8'd128; mode_16bit = 1'b1; mode_stereo = 1'b0;
        push(8'h11); push(8'h11);
        tick();
        repeat (6) cycle();
        chk("ur_prior_left", 32'(left_data), 32'h1111);
        push(8'haa);
        clear_log();
        tick();
        repeat (8) cycle();
        chk("ur_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("ur_count", 32'(ur_cnt), 32'd1);
        chk("ur_cyc", 32'(last_ur), 32'(t0 + 3));
        chk("ur_strobes", 32'(st_cnt), 32'd0);
        chk("ur_left", 32'(left_data), 32'h1111);
        chk("ur_right", 32'(right_data), 32'h1111);
        chk("ur_busy", 32'(busy), 32'h0);

        // Back-to-back ticks: one pending frame, extras dropped, mid-frame mode change ignored
        mode_16bit = 1'b1; mode_stereo = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        clear_log();
        tick();
        sample_tick = 1'b1;
        cycle();
        mode_16bit = 1'b0; mode_stereo = 1'b0;
        cycle();
        cycle();
        sample_tick = 1'b0;
        cycle();
        mode_16bit = 1'b1; mode_stereo = 1'b1;
        repeat (20) cycle();
        chk("pend_frames", 32'(st_cnt), 32'd2);
        chk("pend_rd_cnt", 32'(rd_cnt), 32'd8);
        chk("pend_first_st", 32'(first_st), 32'(t0 + 9));
        chk("pend_last_st", 32'(last_st), 32'(t0 + 18));
        chk("pend_first_left", 32'(st_l0), 32'h0201);
        chk("pend_first_right", 32'(st_r0), 32'h0403);
        chk("pend_left", 32'(left_data), 32'h0605);
        chk("pend_right", 32'(right_data), 32'h0807);

        // Reset during capture of the second byte
        push(8'ha1); push(8'ha2); push(8'ha3); push(8'ha4);
        clear_log();
        tick();
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_left", 32'(left_data), 32'h0);
        chk("rst_right", 32'(right_data), 32'h0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobe", 32'(sample_strobe), 32'h0);
        cycle();
        rst = 1'b0;
        push(8'hb1); push(8'hb2);
        clear_log();
        tick();
        repeat (11) cycle();
        chk("post_rst_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("post_rst_strobe", 32'(last_st), 32'(t0 + 9));
        chk("post_rst_left", 32'(left_data), 32'ha4a3);
        chk("post_rst_right", 32'(right_data), 32'hb2b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pcm_fifo_reader.md
Name: pcm_fifo_reader

Overview:
- Consumer side of the audio byte FIFO.
- Paces sample fetches with a phase accumulator clocked by the audio sample tick.
- Pops 1, 2 or 4 bytes per frame, depending on width and channel mode, and assembles signed 16-bit left/right samples for the downstream mixer/DAC path.
- Detects and flags underrun when the FIFO runs dry mid-stream.

Parameters:
- RATE_MAX, 128, largest effective rate value; a rate of 128 gives one frame per tick.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sample_tick  input  1  one-cycle pulse at the base audio sample rate
- rate  input  8  phase increment; 0 = stopped; values above RATE_MAX are treated as RATE_MAX
- mode_16bit  input  1  1 = 16-bit samples (little-endian byte pairs), 0 = 8-bit samples
- mode_stereo  input  1  1 = stereo (L then R), 0 = mono
- fifo_rddata  input  8  FIFO read data; valid the cycle after an accepted pop
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO pop request
- left_data  output  16  signed left sample
- right_data  output  16  signed right sample
- sample_strobe  output  1  one-cycle pulse when a new left/right pair is valid
- underrun  output  1  one-cycle pulse when a frame is aborted on empty FIFO
- busy  output  1  high while a frame fetch is in progress

Behaviour:
- Reset is asynchronous. All of the following clear immediately: accumulator, pending flag, byte count, byte buffer, left_data, right_data, sample_strobe, underrun and fifo_rd_en. busy goes low and the FSM returns to IDLE. Reset mid-frame discards the frame, and bytes already popped are lost.
- Accumulator:
  - 7-bit phase acc.
  - On sample_tick: sum[7:0] = {1'b0,acc} + min(rate,128); acc <= sum[6:0]; overflow = sum[7].
  - rate = 0 never overflows.
  - rate = 128 overflows on every tick.
- Frame trigger: overflow while IDLE starts a frame on the next cycle. Overflow while busy sets pending (one deep). A second overflow while pending is already set is dropped silently.
- On frame start, mode_16bit and mode_stereo are latched. They are ignored for the rest of the frame. Byte count N = 1 (8-bit mono), 2 (8-bit stereo or 16-bit mono) or 4 (16-bit stereo).
- FSM states:
  - IDLE -> FETCH on trigger or pending; pending clears on entry to FETCH.
  - FETCH: if fifo_empty, pulse underrun, discard partial bytes, leave outputs unchanged, go to IDLE. Otherwise assert fifo_rd_en for exactly this cycle and go to CAPTURE.
  - CAPTURE: store fifo_rddata into byte slot k (k = 0..N-1). If k < N-1, go to FETCH with k+1. Otherwise update the outputs and go to DONE.
  - DONE: sample_strobe = 1 for this single cycle, then go to IDLE, or directly to FETCH if pending is set.
- Assembly, with b0..b3 in pop order:
  - 8-bit mono: L = R = {b0, 8'h00}.
  - 8-bit stereo: L = {b0, 8'h00}, R = {b1, 8'h00}.
  - 16-bit mono: L = R = {b1, b0}.
  - 16-bit stereo: L = {b1, b0}, R = {b3, b2}.
- Latency, with the overflow tick in cycle T:
  - First fifo_rd_en in T+1.
  - Outputs update and sample_strobe is high in T+2N+1.
  - Each byte costs 2 cycles (FETCH + CAPTURE).
- fifo_rd_en is never asserted while fifo_empty is high, and never on two consecutive cycles.
- busy is high in FETCH, CAPTURE and DONE.
- left_data and right_data hold their values between strobes and after an underrun.
- A sample_tick arriving in the same cycle as DONE updates the accumulator normally. If it overflows, it starts the next frame immediately (same path as pending).

Test Plan:
- Reset, rate=128, 8-bit mono, FIFO holds 0x80 -> one tick at T: rd_en in T+1; strobe in T+3; L=R=0x8000.
- rate=128, 16-bit stereo, FIFO 0x34,0x12,0x78,0x56 -> 4 rd_en pulses on alternating cycles T+1..T+7; strobe in T+9; L=0x1234, R=0x5678.
- rate=64, 8-bit stereo, 4 ticks -> exactly 2 frames (overflow on ticks 2 and 4); rate=0 with 10 ticks -> no rd_en, no strobe.
- 16-bit mono, FIFO holds a single byte 0xAA, prior L=R=0x1111 -> one pop, then underrun pulse; no strobe; outputs stay 0x1111; busy low afterwards.
- rate=128, ticks on consecutive cycles during a 16-bit stereo frame -> pending honoured once, extra overflows dropped; exactly 2 frames fetched; mode change mid-frame has no effect on the current frame.
- Assert rst during CAPTURE of byte 2 -> outputs 0, rd_en 0, busy 0 immediately; the next tick after release starts a clean frame from b0.
